libv_stream_mux: RTL and testbench
==================================

# libv_stream_mux

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes, round-robin arbitration, optional packet lock and a registered output stage. It is the sequential successor to the one-hot combinational mux. Selection is no longer supplied by the caller: the block derives it from requesting channels and holds it across a multi-beat packet. It sits between per-channel producers (queues, decoders) and a single shared downstream consumer.

## Interface
- `N`, default 4: number of input channels, N ≥ 2.
- `W`, default 32: data width per channel, W ≥ 1.
- `LOCK`, default 1: 1 holds a grant until the `last` beat is accepted; 0 re-arbitrates every beat.
- `clk`  in  1  the only clock. All state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low. Sampled on the rising edge of `clk`.
- `in_vld`  in  N  per-channel beat valid.
- `in_data`  in  N×W  per-channel beat payload, packed `[N-1:0][W-1:0]`.
- `in_last`  in  N  per-channel final beat of packet.
- `in_rdy`  out  N  per-channel accept, at most one bit set.
- `out_vld`  out  1  registered output beat valid.
- `out_data`  out  W  registered payload.
- `out_last`  out  1  registered last flag.
- `out_sel`  out  N  one-hot source channel of the current output beat. All zero when `out_vld` = 0.
- `out_rdy`  in  1  downstream accept.

## Operation
- Handshake: a beat transfers on channel i when `in_vld[i] & in_rdy[i]`. The output beat transfers when `out_vld & out_rdy`. Producers must hold valid and payload stable until accepted. The block never drops or duplicates a beat.
- Output stage is one register. `adv = ~out_vld | out_rdy`. When `adv` is high, the register loads the granted beat, or clears `out_vld` and `out_sel` if nothing is granted. When `adv` is low, it holds.
- `in_rdy[i] = grant[i] & adv`. `grant` is one-hot or zero and combinational from `in_vld`, the pointer and the lock state. `in_rdy` does not depend on `in_vld[i]` of other channels when locked.
- Arbitration uses round-robin pointer `ptr` (range 0..N-1). When unlocked, the grant goes to the first valid channel searching `ptr, ptr+1, …, N-1, 0, …` modulo N.
- Pointer update: on every input acceptance from channel g that ends arbitration, `ptr <= (g+1) mod N`. Acceptance ends arbitration when LOCK=0, or when LOCK=1 and the beat has `in_last`. Otherwise `ptr` is unchanged.
- Lock state machine, LOCK=1 only:
  - Two states: IDLE and LOCKED(g), with `lock_idx` register.
  - IDLE → LOCKED(g) on acceptance of a non-last beat from g.
  - LOCKED(g) → IDLE on acceptance of a last beat from g.
  - In LOCKED(g), `grant` = onehot(g) regardless of other valids. If `in_vld[g]` = 0, grant is zero (bubble) and other channels wait.
  - A single-beat packet (`in_last` = 1 on first beat) never enters LOCKED.
- LOCK=0: the lock state is held at IDLE; `in_last` is passed through only.
- `out_data` and `out_last` hold their last loaded values when `out_vld` = 0. Only `out_vld` and `out_sel` are cleared.

## Timing
- Reset, when `rst_n` = 0 at an edge:
  - `out_vld` = 0, `out_data` = 0, `out_last` = 0, `out_sel` = 0.
  - `ptr` = 0, lock state = IDLE.
  - `in_rdy` = 0 for the cycle `rst_n` is low.
- Reset mid-packet abandons the lock and any registered beat. The beat is not re-presented.
- Latency: a beat accepted at edge k is visible on `out_*` after edge k. Minimum 1 cycle, input to output.
- Throughput: 1 beat/cycle sustained while `out_rdy` = 1, including when switching channels. There is no dead cycle at packet or grant boundaries.
- Backpressure: when `out_rdy` = 0 and `out_vld` = 1, all `in_rdy` = 0 in that cycle. Output is held stable.
- Simultaneous events in one cycle: output drain and new input accept are both permitted (`adv` = 1 via `out_rdy`).
- `ptr` wraps from N-1 to 0.

## Test plan
- Reset, then idle: all inputs 0, `rst_n` = 1 for 5 cycles. Required: `out_vld` = 0, `out_sel` = 0, `in_rdy` = 0, `out_data` = 0 throughout.
- Round-robin, N=4, LOCK=0: all four `in_vld` held at 1 with single beats, `out_rdy` = 1. Required grant order: ch0, 1, 2, 3, 0, 1. Output beats appear one cycle later, back-to-back, with `out_sel` = 0001, 0010, 0100, 1000, …
- Packet lock, LOCK=1: ch2 sends a 3-beat packet with data 0xA0, 0xA1, 0xA2 (last on 0xA2) while ch0 and ch1 stay valid. Required: output 0xA0, 0xA1, 0xA2 contiguous with `out_sel` = 0100. Then ch0 is granted next, since `ptr` = 3 and 3 is invalid, so the search wraps to 0.
- Locked bubble: ch1 is locked and drops `in_vld` for 2 cycles mid-packet while ch3 is valid. Required: `in_rdy[3]` = 0 throughout and `out_vld` = 0 for 2 cycles. The packet resumes on ch1.
- Backpressure: `out_rdy` = 0 for 3 cycles with `out_vld` = 1, data 0x55. Required: `out_data` stays 0x55, all `in_rdy` = 0, no input beat is lost. After release, the next beat follows on the very next cycle.
- Reset mid-packet: assert `rst_n` = 0 during beat 2 of a 4-beat packet on ch1. Required: `out_vld` = 0, `ptr` = 0 and lock cleared next cycle. A new single beat on ch3 is granted immediately.

Source files
------------

// File: rtl/libv_stream_mux.sv
// rtl/libv_stream_mux.sv - N-to-1 round-robin stream mux with packet lock and registered output
module libv_stream_mux #(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int LOCK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        in_vld,
  input  logic [N-1:0][W-1:0] in_data,
  input  logic [N-1:0]        in_last,
  output logic [N-1:0]        in_rdy,
  output logic                out_vld,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  output logic [N-1:0]        out_sel,
  input  logic                out_rdy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] lock_idx_q;
  logic [IW-1:0] lock_idx_d;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  grant;
  logic          gnt_any;
  logic          adv;
  logic          acc;
  logic          acc_last;
  logic [W-1:0]  sel_data;

  // The output register can take a new beat when empty or draining this cycle.
  assign adv      = ~out_vld | out_rdy;
  // Ready is suppressed while reset is asserted so no beat is consumed and lost.
  assign in_rdy   = (rst_n && adv) ? grant : '0;
  // A grant always implies the granted channel is valid, so this is a real transfer.
  assign acc      = rst_n & adv & gnt_any;
  assign acc_last = in_last[gnt_idx];
  assign sel_data = in_data[gnt_idx];

  // Grant: locked channel only, otherwise first valid channel at or after ptr.
  always_comb begin
    logic [IW-1:0] idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    if (state_q == ST_LOCKED) begin
      gnt_idx = lock_idx_q;
      if (in_vld[lock_idx_q]) begin
        grant[lock_idx_q] = 1'b1;
        gnt_any           = 1'b1;
      end
    end else begin
      // Walk the search order backwards so the nearest candidate to ptr is written last.
      for (int k = N - 1; k >= 0; k--) begin
        idx = IW'((int'(ptr_q) + k) % N);
        if (in_vld[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          gnt_idx    = idx;
          gnt_any    = 1'b1;
        end
      end
    end
  end

  // Next state: enter lock on a non-last beat, release and advance ptr when arbitration ends.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    if (acc) begin
      if ((LOCK == 0) || acc_last) begin
        ptr_d   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        state_d = ST_IDLE;
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = gnt_idx;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
    end
  end

  // Output stage: load the granted beat, or go empty; payload is kept when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_sel  <= '0;
    end else if (adv) begin
      if (acc) begin
        out_vld  <= 1'b1;
        out_data <= sel_data;
        out_last <= acc_last;
        out_sel  <= grant;
      end else begin
        out_vld  <= 1'b0;
        out_sel  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_libv_stream_mux.sv
// tb/tb_libv_stream_mux.sv - scoreboard bench for libv_stream_mux
module tb_libv_stream_mux;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           gap;
  } beat_t;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [N-1:0] sel;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        in_vld = '0;
  logic [N-1:0][W-1:0] in_data = '0;
  logic [N-1:0]        in_last = '0;
  logic [N-1:0]        in_rdy;
  logic                out_vld;
  logic [W-1:0]        out_data;
  logic                out_last;
  logic [N-1:0]        out_sel;
  logic                out_rdy;

  beat_t src_q[N][$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  libv_stream_mux #(.N(N), .W(W), .LOCK(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel),
    .out_rdy  (out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int ch, input int d, input int l, input int gap = 0);
    beat_t b;
    b.data = W'(d);
    b.last = (l != 0);
    b.gap  = gap;
    src_q[ch].push_back(b);
  endtask

  task automatic expect_beat(input int d, input int l, input int ch);
    exp_t e;
    e.data = W'(d);
    e.last = (l != 0);
    e.sel  = N'(1) << ch;
    sb.push_back(e);
  endtask

  task automatic wait_data(input int d);
    int t;
    t = 0;
    @(negedge clk);
    while (!(out_vld === 1'b1 && out_data === W'(d)) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("wait_data_timeout", 32'(t < 40), 32'd1);
  endtask

  task automatic expect_burst(input int n);
    int t;
    t = 0;
    @(negedge clk);
    while (out_vld !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("burst_start", 32'(t < 40), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk("burst_b2b_vld", 32'(out_vld), 32'd1);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(t < 60), 32'd1);
  endtask

  // Producer model: retire accepted heads, then present the next head after its gap.
  always begin : producer
    logic [N-1:0] pacc;
    @(posedge clk);
    pacc = in_vld & in_rdy;
    #1;
    for (int c = 0; c < N; c++) begin
      if (pacc[c] && src_q[c].size() > 0) src_q[c].delete(0);
      if (src_q[c].size() == 0) begin
        in_vld[c] = 1'b0;
      end else if (src_q[c][0].gap > 0) begin
        src_q[c][0].gap = src_q[c][0].gap - 1;
        in_vld[c] = 1'b0;
      end else begin
        in_vld[c]  = 1'b1;
        in_data[c] = src_q[c][0].data;
        in_last[c] = src_q[c][0].last;
      end
    end
  end

  // Monitor: every output transfer must match the head of the scoreboard.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    if (out_vld === 1'b1 && out_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra actual=%0h required=none", out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.data));
        chk("sb_last", 32'(out_last), 32'(e.last));
        chk("sb_sel", 32'(out_sel), 32'(e.sel));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_out_vld", 32'(out_vld), 32'd0);
      chk("idle_out_sel", 32'(out_sel), 32'd0);
      chk("idle_in_rdy", 32'(in_rdy), 32'd0);
      chk("idle_out_data", 32'(out_data), 32'd0);
    end

    // Round-robin over single beats: ch0..3 twice, back-to-back.
    @(posedge clk);
    #2;
    out_rdy = 1'b1;
    for (int c = 0; c < N; c++) begin
      push(c, 'h10 + c, 1);
      push(c, 'h20 + c, 1);
    end
    for (int c = 0; c < N; c++) expect_beat('h10 + c, 1, c);
    for (int c = 0; c < N; c++) expect_beat('h20 + c, 1, c);
    expect_burst(8);

    // Move ptr to 2, then a locked 3-beat packet on ch2 with ch0/ch1 competing.
    @(posedge clk);
    #2;
    push(1, 'h31, 1);
    expect_beat('h31, 1, 1);
    expect_burst(1);
    @(posedge clk);
    #2;
    push(2, 'hA0, 0);
    push(2, 'hA1, 0);
    push(2, 'hA2, 1);
    push(0, 'hB0, 1);
    push(1, 'hB1, 1);
    expect_beat('hA0, 0, 2);
    expect_beat('hA1, 0, 2);
    expect_beat('hA2, 1, 2);
    expect_beat('hB0, 1, 0);
    expect_beat('hB1, 1, 1);
    expect_burst(5);

    // Locked bubble: ch1 stalls two cycles mid-packet while ch3 waits.
    @(posedge clk);
    #2;
    push(0, 'h40, 1);
    expect_beat('h40, 1, 0);
    expect_burst(1);
    @(posedge clk);
    #2;
    push(1, 'hC0, 0);
    push(1, 'hC1, 0, 2);
    push(1, 'hC2, 1);
    push(3, 'hD3, 1);
    expect_beat('hC0, 0, 1);
    expect_beat('hC1, 0, 1);
    expect_beat('hC2, 1, 1);
    expect_beat('hD3, 1, 3);
    wait_data('hC0);
    chk("bubble_rdy3", 32'(in_rdy[3]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bubble_out_vld", 32'(out_vld), 32'd0);
      chk("bubble_rdy3", 32'(in_rdy[3]), 32'd0);
    end
    @(negedge clk);
    chk("bubble_resume_vld", 32'(out_vld), 32'd1);
    chk("bubble_resume_sel", 32'(out_sel), 32'b0010);
    wait_drain();

    // Backpressure: 0x55 held three cycles, then 0x56 follows immediately.
    @(posedge clk);
    #2;
    out_rdy = 1'b0;
    push(0, 'h55, 1);
    push(1, 'h56, 1);
    push(1, 'h57, 1);
    expect_beat('h55, 1, 0);
    expect_beat('h56, 1, 1);
    expect_beat('h57, 1, 1);
    wait_data('h55);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_vld", 32'(out_vld), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h55);
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
    end
    @(posedge clk);
    #2;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 32'(in_rdy), 32'b0010);
    @(negedge clk);
    chk("bp_next_vld", 32'(out_vld), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'h56);
    wait_drain();

    // Reset during beat 2 of a 4-beat ch1 packet; then a single beat on ch3.
    @(posedge clk);
    #2;
    push(1, 'hE0, 0);
    push(1, 'hE1, 0);
    push(1, 'hE2, 0);
    push(1, 'hE3, 1);
    expect_beat('hE0, 0, 1);
    wait_data('hE0);
    rst_n = 1'b0;
    src_q[1].delete();
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push(3, 'hF3, 1);
    expect_beat('hF3, 1, 3);
    @(negedge clk);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    chk("rst_grant3", 32'(in_rdy), 32'b1000);
    wait_drain();

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
